// File: rtl/ok_cmd_sequencer.sv
// ok_cmd_sequencer
//   Host-command controller for FrontPanel wire endpoints. The host posts a
//   command by flipping cmd_word[15]. Each command runs on one shared adder,
//   and an ack toggle plus a status word are returned on wire-outs.
//
// Ports
//   ti_clk    FrontPanel target-interface clock (sole clock)
//   rst_n     asynchronous active-low reset (assertion is async, release is
//             synchronised internally)
//   cmd_word  [15] toggle, [14:12] opcode, [11:8] count, [3:0] led pattern
//   opa, opb  operands A / B
//   result    last arithmetic result
//   status    [15] ack, [14] busy, [13] carry/borrow, [12] overrun (sticky),
//             [11] bad opcode, [10:8] last opcode, [7:4] remaining count
//   led       board LEDs, active-low
//
// Opcodes: 0 NOP (clears overrun), 1 ADD, 2 SUB, 3 LEDSET, 4 BLINK,
//          5 MAC (opa + opb*count), 6/7 bad.
module ok_cmd_sequencer #(
  parameter int DW        = 16,
  parameter int BLINK_DIV = 24
) (
  input  logic          ti_clk,
  input  logic          rst_n,
  input  logic [15:0]   cmd_word,
  input  logic [DW-1:0] opa,
  input  logic [DW-1:0] opb,
  output logic [DW-1:0] result,
  output logic [15:0]   status,
  output logic [3:0]    led
);

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_ADD   = 3'd1;
  localparam logic [2:0] OP_SUB   = 3'd2;
  localparam logic [2:0] OP_LED   = 3'd3;
  localparam logic [2:0] OP_BLINK = 3'd4;
  localparam logic [2:0] OP_MAC   = 3'd5;

  typedef enum logic [1:0] {ST_ARM, ST_IDLE, ST_EXEC} state_t;

  // Command captured on the toggle edge; wire-ins may change while it runs.
  typedef struct packed {
    logic [2:0]    op;
    logic [3:0]    pat;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } req_t;

  // ---------------------------------------------------------------------
  // Reset: assert asynchronously, release on a clock edge.
  // ---------------------------------------------------------------------
  logic [1:0] rst_sync;
  logic       rst_i_n;

  always_ff @(posedge ti_clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_i_n = rst_sync[1];

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_t               state;
  req_t                 req;
  logic                 tog_seen;
  logic                 ack, busy, carry, overrun, bad;
  logic [2:0]           last_op;
  logic [3:0]           cnt;
  logic [3:0]           led_reg;
  logic [DW-1:0]        acc;
  logic                 mac_c;
  logic                 blink_half;   // 0: pattern phase, 1: dark phase
  logic [BLINK_DIV-1:0] pre;

  logic                 new_tog;
  logic [DW:0]          add_sum;
  logic [DW-1:0]        sub_diff;
  logic [DW:0]          mac_sum;
  logic                 pre_end;

  // Fields of cmd_word that carry nothing for this block.
  logic                 unused_cmd_bits;
  assign unused_cmd_bits = ^cmd_word[7:4];

  assign new_tog  = cmd_word[15] != tog_seen;
  assign add_sum  = {1'b0, req.a} + {1'b0, req.b};
  assign sub_diff = req.a - req.b;
  assign mac_sum  = {1'b0, acc} + {1'b0, req.b};
  assign pre_end  = &pre;

  // ---------------------------------------------------------------------
  // Completion decode for the command in EXEC
  // ---------------------------------------------------------------------
  logic          done;
  logic [DW-1:0] fin_res;
  logic          fin_carry;
  logic          fin_bad;

  always_comb begin
    done      = 1'b0;
    fin_res   = result;
    fin_carry = 1'b0;
    fin_bad   = 1'b0;
    case (req.op)
      OP_NOP, OP_LED: done = 1'b1;
      OP_ADD: begin
        done      = 1'b1;
        fin_res   = add_sum[DW-1:0];
        fin_carry = add_sum[DW];
      end
      OP_SUB: begin
        done      = 1'b1;
        fin_res   = sub_diff;
        fin_carry = req.a < req.b;
      end
      OP_BLINK: begin
        // Last dark phase ending on the final pair closes the command.
        done = (cnt == 4'd0) || (pre_end && blink_half && cnt == 4'd1);
      end
      OP_MAC: begin
        if (cnt == 4'd0) begin
          done      = 1'b1;
          fin_res   = acc;
          fin_carry = mac_c;
        end else begin
          // Finishing edge is the one that performs the last add.
          done      = cnt == 4'd1;
          fin_res   = mac_sum[DW-1:0];
          fin_carry = mac_c | mac_sum[DW];
        end
      end
      default: begin
        done    = 1'b1;
        fin_bad = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------
  always_ff @(posedge ti_clk or negedge rst_i_n) begin
    if (!rst_i_n) begin
      state      <= ST_ARM;
      req        <= '0;
      tog_seen   <= 1'b0;
      ack        <= 1'b0;
      busy       <= 1'b0;
      carry      <= 1'b0;
      overrun    <= 1'b0;
      bad        <= 1'b0;
      last_op    <= 3'd0;
      cnt        <= 4'd0;
      led_reg    <= 4'd0;
      acc        <= '0;
      mac_c      <= 1'b0;
      blink_half <= 1'b0;
      pre        <= '0;
      result     <= '0;
    end else begin
      case (state)
        // Adopt whatever toggle level the host left behind, so a command
        // posted before reset is not replayed.
        ST_ARM: begin
          tog_seen <= cmd_word[15];
          state    <= ST_IDLE;
        end

        ST_IDLE: begin
          if (new_tog) begin
            tog_seen   <= cmd_word[15];
            req.op     <= cmd_word[14:12];
            req.pat    <= cmd_word[3:0];
            req.a      <= opa;
            req.b      <= opb;
            busy       <= 1'b1;
            acc        <= opa;
            mac_c      <= 1'b0;
            blink_half <= 1'b0;
            pre        <= '0;
            if (cmd_word[14:12] == OP_MAC || cmd_word[14:12] == OP_BLINK)
              cnt <= cmd_word[11:8];
            else
              cnt <= 4'd0;
            if (cmd_word[14:12] == OP_BLINK)
              led_reg <= cmd_word[3:0];
            state <= ST_EXEC;
          end
        end

        ST_EXEC: begin
          // A toggle while busy is consumed and dropped.
          if (new_tog) begin
            tog_seen <= cmd_word[15];
            overrun  <= 1'b1;
          end

          if (req.op == OP_MAC && cnt != 4'd0) begin
            acc   <= mac_sum[DW-1:0];
            mac_c <= mac_c | mac_sum[DW];
            cnt   <= cnt - 4'd1;
          end

          // cnt counts pattern/dark pairs; it steps at the end of each dark phase.
          if (req.op == OP_BLINK && cnt != 4'd0) begin
            pre <= pre + BLINK_DIV'(1);
            if (pre_end) begin
              if (!blink_half) begin
                led_reg    <= 4'd0;
                blink_half <= 1'b1;
              end else begin
                led_reg    <= req.pat;
                blink_half <= 1'b0;
                cnt        <= cnt - 4'd1;
              end
            end
          end

          if (done) begin
            result  <= fin_res;
            carry   <= fin_carry;
            bad     <= fin_bad;
            last_op <= req.op;
            ack     <= tog_seen;
            busy    <= 1'b0;
            cnt     <= 4'd0;
            if (req.op == OP_LED || req.op == OP_BLINK)
              led_reg <= req.pat;
            // A dropped toggle on this same edge keeps overrun set.
            if (req.op == OP_NOP && !new_tog)
              overrun <= 1'b0;
            state <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign status = {ack, busy, carry, overrun, bad, last_op, cnt, 4'h0};
  assign led    = ~led_reg;

endmodule

// File: tb/tb_ok_cmd_sequencer.sv
// Scoreboard bench for ok_cmd_sequencer (BLINK_DIV=3). Stimulus pushes
// expected completions (checked on busy falling) and cycle-stamped samples;
// a monitor on the falling clock edge pops and compares.
module tb_ok_cmd_sequencer;

  logic        ti_clk;
  logic        rst_n;
  logic [15:0] cmd_word;
  logic [15:0] opa, opb;
  logic [15:0] result;
  logic [15:0] status;
  logic [3:0]  led;

  ok_cmd_sequencer #(.DW(16), .BLINK_DIV(3)) dut (
    .ti_clk   (ti_clk),
    .rst_n    (rst_n),
    .cmd_word (cmd_word),
    .opa      (opa),
    .opb      (opb),
    .result   (result),
    .status   (status),
    .led      (led)
  );

  initial ti_clk = 1'b0;
  always #5 ti_clk = ~ti_clk;

  int cyc = 0;
  always @(posedge ti_clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    string       name;
    logic [15:0] res;
    logic [15:0] st;
    logic [15:0] mask;
  } ack_t;

  typedef struct {
    int          cyc;
    string       name;
    int          sel;   // 0 status, 1 result, 2 led
    logic [15:0] val;
    logic [15:0] mask;
  } smp_t;

  ack_t ack_q[$];
  smp_t smp_q[$];
  int   checks = 0;
  int   passes = 0;
  logic tgl;

  task automatic step(input int n);
    repeat (n) @(negedge ti_clk);
    #1;
  endtask

  // Post a command; e1 is the cycle stamp of the edge that sees the toggle.
  task automatic post(input logic [2:0] op, input logic [3:0] c,
                      input logic [3:0] pat, input logic [15:0] a,
                      input logic [15:0] b, output int e1);
    tgl      = ~tgl;
    opa      = a;
    opb      = b;
    cmd_word = {tgl, op, c, 4'h0, pat};
    e1       = cyc + 1;
  endtask

  task automatic exp_ack(input string nm, input int c, input logic [15:0] r,
                         input logic [15:0] s, input logic [15:0] m);
    ack_t e;
    e.cyc = c; e.name = nm; e.res = r; e.st = s; e.mask = m;
    ack_q.push_back(e);
  endtask

  task automatic exp_smp(input string nm, input int c, input int sel,
                         input logic [15:0] v, input logic [15:0] m);
    smp_t e;
    e.cyc = c; e.name = nm; e.sel = sel; e.val = v; e.mask = m;
    smp_q.push_back(e);
  endtask

  // Monitor
  initial begin
    logic prev_busy;
    prev_busy = 1'b0;
    forever begin
      int          i;
      ack_t        a;
      smp_t        s;
      logic [15:0] act;
      @(negedge ti_clk);
      if (!rst_n) begin
        prev_busy = 1'b0;
      end else begin
        if (prev_busy && !status[14]) begin
          checks++;
          if (ack_q.size() == 0) begin
            $display("FAIL unexpected_ack: cyc=%0d result=%h status=%h, none expected",
                     cyc, result, status);
          end else begin
            a = ack_q.pop_front();
            if (cyc != a.cyc || result !== a.res ||
                (status & a.mask) !== (a.st & a.mask))
              $display("FAIL %s: got cyc=%0d result=%h status=%h, want cyc=%0d result=%h status=%h (mask %h)",
                       a.name, cyc, result, status, a.cyc, a.res, a.st, a.mask);
            else
              passes++;
          end
        end
        prev_busy = status[14];
      end
      i = 0;
      while (i < smp_q.size()) begin
        if (smp_q[i].cyc == cyc) begin
          s = smp_q[i];
          case (s.sel)
            0:       act = status;
            1:       act = result;
            default: act = {12'h000, led};
          endcase
          checks++;
          if ((act & s.mask) !== (s.val & s.mask))
            $display("FAIL %s: cyc=%0d got %h, want %h (mask %h)",
                     s.name, cyc, act, s.val, s.mask);
          else
            passes++;
          smp_q.delete(i);
        end else begin
          i++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passes, checks);
    $fatal(1);
  end

  // Stimulus
  initial begin
    int e;
    rst_n    = 1'b0;
    cmd_word = 16'h8000;   // toggle held high across reset
    opa      = '0;
    opb      = '0;
    tgl      = 1'b1;

    step(3);
    exp_smp("rst_status", cyc + 1, 0, 16'h0000, 16'hFFFF);
    exp_smp("rst_led",    cyc + 1, 2, 16'h000F, 16'hFFFF);
    exp_smp("rst_result", cyc + 1, 1, 16'h0000, 16'hFFFF);
    step(2);
    rst_n = 1'b1;
    exp_smp("hold_status", cyc + 10, 0, 16'h0000, 16'hFFFF);
    exp_smp("hold_led",    cyc + 10, 2, 16'h000F, 16'hFFFF);
    step(12);

    // ADD with carry out
    post(3'd1, 4'd0, 4'h0, 16'hFFFF, 16'h0002, e);
    exp_smp("add_busy", e, 0, 16'h4000, 16'hFFFF);
    exp_ack("add_carry", e + 1, 16'h0001, 16'h2100, 16'hFFFF);
    step(4);

    // SUB with borrow, then without
    post(3'd2, 4'd0, 4'h0, 16'h0003, 16'h0005, e);
    exp_ack("sub_borrow", e + 1, 16'hFFFE, 16'hA200, 16'hFFFF);
    step(4);
    post(3'd2, 4'd0, 4'h0, 16'h1234, 16'h0234, e);
    exp_ack("sub_plain", e + 1, 16'h1000, 16'h0200, 16'hFFFF);
    step(4);

    // MAC count=4: remaining count 4..1 while busy
    post(3'd5, 4'd4, 4'h0, 16'h0010, 16'h0003, e);
    exp_smp("mac_cnt4", e,     0, 16'h4240, 16'hFFFF);
    exp_smp("mac_cnt3", e + 1, 0, 16'h4230, 16'hFFFF);
    exp_smp("mac_cnt2", e + 2, 0, 16'h4220, 16'hFFFF);
    exp_smp("mac_cnt1", e + 3, 0, 16'h4210, 16'hFFFF);
    exp_ack("mac4", e + 4, 16'h001C, 16'h8500, 16'hFFFF);
    step(7);

    // MAC count=0 returns opa
    post(3'd5, 4'd0, 4'h0, 16'hABCD, 16'h1111, e);
    exp_ack("mac0", e + 1, 16'hABCD, 16'h0500, 16'hFFFF);
    step(4);

    // MAC with an intermediate carry: FFF0 +8 +8 +8
    post(3'd5, 4'd3, 4'h0, 16'hFFF0, 16'h0008, e);
    exp_ack("mac_carry", e + 3, 16'h0008, 16'hA500, 16'hFFFF);
    step(6);

    // LEDSET
    post(3'd3, 4'd0, 4'h6, 16'h0000, 16'h0000, e);
    exp_smp("ledset_before", e,     2, 16'h000F, 16'hFFFF);
    exp_smp("ledset_after",  e + 1, 2, 16'h0009, 16'hFFFF);
    exp_ack("ledset", e + 1, 16'h0008, 16'h0300, 16'hFFFF);
    step(4);

    // Bad opcodes
    post(3'd6, 4'd0, 4'h0, 16'h1111, 16'h1111, e);
    exp_ack("bad6", e + 1, 16'h0008, 16'h8E00, 16'hFFFF);
    step(4);
    post(3'd7, 4'd0, 4'h0, 16'h1111, 16'h1111, e);
    exp_ack("bad7", e + 1, 16'h0008, 16'h0F00, 16'hFFFF);
    step(4);

    // NOP
    post(3'd0, 4'd0, 4'h0, 16'h0000, 16'h0000, e);
    exp_ack("nop", e + 1, 16'h0008, 16'h8000, 16'hFFFF);
    step(4);

    // BLINK count=2, pattern A, 8-cycle phases; ADD posted mid-blink
    post(3'd4, 4'd2, 4'hA, 16'h0000, 16'h0000, e);
    exp_smp("blink_p1a", e,      2, 16'h0005, 16'hFFFF);
    exp_smp("blink_p1b", e + 7,  2, 16'h0005, 16'hFFFF);
    exp_smp("blink_p2a", e + 8,  2, 16'h000F, 16'hFFFF);
    exp_smp("blink_p2b", e + 15, 2, 16'h000F, 16'hFFFF);
    exp_smp("blink_p3a", e + 16, 2, 16'h0005, 16'hFFFF);
    exp_smp("blink_p3b", e + 23, 2, 16'h0005, 16'hFFFF);
    exp_smp("blink_p4a", e + 24, 2, 16'h000F, 16'hFFFF);
    exp_smp("blink_p4b", e + 31, 2, 16'h000F, 16'hFFFF);
    exp_smp("blink_end", e + 32, 2, 16'h0005, 16'hFFFF);
    exp_smp("blink_hold", e + 39, 2, 16'h0005, 16'hFFFF);
    exp_ack("blink2", e + 32, 16'h0008, 16'h1400, 16'h7FFF);
    step(10);
    begin
      int o;
      post(3'd1, 4'd0, 4'h0, 16'h0001, 16'h0001, o);
      exp_smp("overrun_set", o, 0, 16'hD000, 16'hFF0F);
    end
    step(30);

    // NOP clears overrun
    post(3'd0, 4'd0, 4'h0, 16'h0000, 16'h0000, e);
    exp_ack("nop_clear", e + 1, 16'h0008, 16'h0000, 16'hFFFF);
    step(4);

    // BLINK count=0
    post(3'd4, 4'd0, 4'h3, 16'h0000, 16'h0000, e);
    exp_smp("blink0_led", e + 1, 2, 16'h000C, 16'hFFFF);
    exp_ack("blink0", e + 1, 16'h0008, 16'h8400, 16'hFFFF);
    step(4);

    // Reset in the middle of a long MAC
    post(3'd5, 4'd15, 4'h0, 16'h0001, 16'h0001, e);
    exp_smp("mac15_mid", e + 2, 0, 16'hC4D0, 16'hFFFF);
    step(5);
    rst_n = 1'b0;
    exp_smp("midrst_status", cyc + 1, 0, 16'h0000, 16'hFFFF);
    exp_smp("midrst_result", cyc + 1, 1, 16'h0000, 16'hFFFF);
    exp_smp("midrst_led",    cyc + 1, 2, 16'h000F, 16'hFFFF);
    step(2);
    rst_n = 1'b1;
    step(6);
    post(3'd1, 4'd0, 4'h0, 16'h1111, 16'h2222, e);
    exp_ack("add_after_rst", e + 1, 16'h3333, 16'h8100, 16'hFFFF);
    step(6);

    foreach (ack_q[k]) begin
      checks++;
      $display("FAIL %s: completion never seen, want cyc=%0d", ack_q[k].name, ack_q[k].cyc);
    end
    foreach (smp_q[k]) begin
      checks++;
      $display("FAIL %s: sample never taken, want cyc=%0d", smp_q[k].name, smp_q[k].cyc);
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/ok_cmd_sequencer.md
Name: ok_cmd_sequencer

Overview:
Host-command controller between the okWireIn/okWireOut endpoints and the board datapath (16-bit adder, LEDs). The host posts commands over three wire-ins using a toggle handshake, since there is no trigger endpoint. The block sequences each command on a single shared adder: ADD, SUB, iterative multiply-accumulate, LED set, LED blink. It returns the result and a status/ack word on two wire-outs.

Parameters:
DW, 16, data width of operands/result; status layout below assumes 16.
BLINK_DIV, 24, blink phase length = 2^BLINK_DIV ti_clk cycles; must be >= 1.

Ports:
ti_clk  input  1  FrontPanel target-interface clock; sole clock.
rst_n  input  1  asynchronous active-low reset.
cmd_word  input  16  from wire-in 0x00: [15] cmd toggle, [14:12] opcode, [11:8] count, [3:0] led pattern; others ignored.
opa  input  DW  operand A, from wire-in 0x01.
opb  input  DW  operand B, from wire-in 0x02.
result  output  DW  to wire-out 0x21.
status  output  16  to wire-out 0x20: [15] ack toggle, [14] busy, [13] carry/borrow, [12] overrun (sticky), [11] bad opcode, [10:8] last opcode, [7:4] remaining count, [3:0] 0.
led  output  4  board LEDs, active-low (led = ~led_reg).

Behaviour:
- Reset (async assert, sync release): result=0, status=0, led_reg=0 (led=4'hF), state=ARM, tog_seen=0, acc=0, cnt=0.
- ARM: one cycle after reset release, tog_seen <= cmd_word[15]; go IDLE. A command held across reset is never re-executed.
- IDLE: new command when cmd_word[15] != tog_seen. On that edge:
  - tog_seen <= cmd_word[15].
  - Capture opcode, count, pattern, opa, opb.
  - busy <= 1; go EXEC.
- Opcodes:
  - 0 NOP: clears overrun.
  - 1 ADD: result = opa+opb mod 2^16; carry = bit 16.
  - 2 SUB: result = opa-opb mod 2^16; borrow = (opa<opb).
  - 3 LEDSET: led_reg = pattern.
  - 4 BLINK: described below.
  - 5 MAC: result = opa + opb*count, one add per cycle, mod 2^16; carry = OR of all add carries.
  - 6,7: bad opcode; set status[11]. result is unchanged.
- Completion: status[11] and status[13] are rewritten at every completion. status[10:8] = opcode. Ack: status[15] <= tog_seen, busy <= 0, return IDLE.
- Latency, counted from the first edge that sees the toggle (edge 1):
  - NOP/ADD/SUB/LEDSET/bad: result and ack update at edge 2.
  - MAC: acc=opa, cnt=count at edge 1. Each EXEC edge: acc += opb, cnt -= 1. Completes on the edge where cnt reaches 0, so ack at edge 1+count. count=0 completes at edge 2 with result=opa.
- BLINK:
  - led_reg = pattern at edge 1, then toggles between pattern and 0 every 2^BLINK_DIV cycles.
  - 2*count phases total; ends with led_reg=pattern; then ack.
  - count=0: ack at edge 2 with led_reg=pattern.
- status[7:4] shows cnt while busy (MAC/BLINK remaining iterations or phases), 0 in IDLE.
- Toggle while busy: command dropped; tog_seen updated (never executed later); overrun <= 1 (sticky until NOP completes); the running command is unaffected.
- Toggle in the same cycle as a completion: treated as busy, so dropped with overrun. The host must wait for ack == its toggle before re-posting.
- Async reset mid-operation: all registers go to reset values immediately; in-flight command abandoned, no ack.
- All counters wrap-free: cnt never decrements below 0, blink prescaler reloads each phase.

Test Plan:
- Reset, then hold cmd_word[15]=1 through release -> no execution, status=0x0000, led=4'hF after 10 cycles.
- opa=0xFFFF, opb=0x0002, toggle with opcode 1 -> at edge 2: result=0x0001, status[13]=1, status[15]=new toggle, status[10:8]=1.
- opcode 5, count=4, opa=0x0010, opb=0x0003 -> busy for 4 cycles with status[7:4] counting 4..1; result=0x001C and ack at edge 5.
- BLINK_DIV=3, opcode 4, count=2, pattern=0xA -> led sequence 0x5 (8 cycles), 0xF (8), 0x5 (8), 0xF (8), then 0x5 held; ack after the 4th phase.
- During the BLINK above, flip toggle with opcode 1 -> ADD not executed, result unchanged, status[12]=1. Next NOP -> status[12]=0.
- Assert rst_n=0 mid-MAC (count=15) -> result=0, status=0, led=4'hF immediately; after release a fresh ADD completes normally at edge 2.
